// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and timing constants for the digital lock
package lock_pkg;

   typedef enum logic [1:0] {IDLE, HOLD, GAP} stretch_state_t;

   localparam int CLK_HZ    = 125_000_000;
   localparam int MS_CYCLES = CLK_HZ / 1000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sat_updn_cnt.sv
// rtl/sat_updn_cnt.sv - saturating up/down event counter with drop strobe
module sat_updn_cnt #(
   parameter int MAX = 3,
   localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         ovf
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         ovf <= 1'b0;
         case ({inc, dec})
            2'b10: begin
               if (cnt == W'(MAX))
                  ovf <= 1'b1;
               else
                  cnt <= cnt + 1'b1;
            end
            2'b01: begin
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches single-cycle events into held levels with a trailing low gap
module pulse_stretch
   import lock_pkg::*;
#(
   parameter int HOLD_PER = 500 * MS_CYCLES,
   parameter int GAP_PER  = 100 * MS_CYCLES,
   parameter int MAX_PEND = 3,
   localparam int PW = $clog2(MAX_PEND + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pulse,
   output logic          level,
   output logic          busy,
   output logic [PW-1:0] pend_cnt,
   output logic          overflow
);

   localparam int CW_RAW = $clog2(max2(HOLD_PER, GAP_PER));
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

   stretch_state_t state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic           start_q;
   logic           gap_done;
   logic           inc;

   assign gap_done = (state == GAP) && (cnt == '0);

   // A pulse on the GAP exit with nothing queued starts HOLD itself, so it is not counted.
   assign inc = pulse && (state != IDLE) && !(gap_done && (pend_cnt == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         level <= (state_nx == HOLD);
         busy  <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      start_q  = 1'b0;
      case (state)
         IDLE: begin
            if (pulse) begin
               state_nx = HOLD;
               cnt_nx   = CW'(HOLD_PER - 1);
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nx = GAP;
               cnt_nx   = CW'(GAP_PER - 1);
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               if ((pend_cnt != '0) || pulse) begin
                  state_nx = HOLD;
                  cnt_nx   = CW'(HOLD_PER - 1);
                  start_q  = (pend_cnt != '0);
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   sat_updn_cnt #(
      .MAX (MAX_PEND)
   ) u_pend (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .dec (start_q),
      .cnt (pend_cnt),
      .ovf (overflow)
   );

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - directed table-driven bench for pulse_stretch
module tb_pulse_stretch;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pulse = 1'b0;
   logic       level;
   logic       busy;
   logic [1:0] pend_cnt;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic pulse;
      logic level;
      logic busy;
      int   pend;
      logic ovf;
   } vec_t;

   vec_t vecs[$];

   pulse_stretch #(
      .HOLD_PER (4),
      .GAP_PER  (2),
      .MAX_PEND (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pulse    (pulse),
      .level    (level),
      .busy     (busy),
      .pend_cnt (pend_cnt),
      .overflow (overflow)
   );

   always #4 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Resets the DUT, checks the reset outputs, and returns just after edge 0.
   task automatic reset_dut(input string tag);
      rst   = 1'b0;
      pulse = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({tag, " reset level"},    int'(level),    0);
      chk({tag, " reset busy"},     int'(busy),     0);
      chk({tag, " reset pend_cnt"}, int'(pend_cnt), 0);
      chk({tag, " reset overflow"}, int'(overflow), 0);
      rst = 1'b1;
      @(posedge clk);
   endtask

   // Each string character is one cycle; cycle 0 follows the first edge after reset release.
   task automatic load_vecs(input string p, input string l, input string b,
                            input string pd, input string o);
      vec_t v;
      vecs.delete();
      for (int i = 0; i < p.len(); i++) begin
         v.pulse = (p[i] == "1");
         v.level = (l[i] == "1");
         v.busy  = (b[i] == "1");
         v.pend  = int'(pd[i]) - 48;
         v.ovf   = (o[i] == "1");
         vecs.push_back(v);
      end
   endtask

   task automatic run_vecs(input string tag);
      for (int c = 0; c < vecs.size(); c++) begin
         #1 pulse = vecs[c].pulse;
         @(negedge clk);
         chk($sformatf("%s c%0d level", tag, c),    int'(level),    int'(vecs[c].level));
         chk($sformatf("%s c%0d busy", tag, c),     int'(busy),     int'(vecs[c].busy));
         chk($sformatf("%s c%0d pend_cnt", tag, c), int'(pend_cnt), vecs[c].pend);
         chk($sformatf("%s c%0d overflow", tag, c), int'(overflow), int'(vecs[c].ovf));
         @(posedge clk);
      end
      #1 pulse = 1'b0;
   endtask

   initial begin
      // Reset held with no clock-edge dependence, then idle after release.
      reset_dut("t1");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("t1 idle c%0d level", c), int'(level), 0);
         chk($sformatf("t1 idle c%0d busy", c),  int'(busy),  0);
         @(posedge clk);
      end

      reset_dut("t2");
      load_vecs("000000000010000000000000",
                "000000000001111000000000",
                "000000000001111110000000",
                "000000000000000000000000",
                "000000000000000000000000");
      run_vecs("t2 single");

      reset_dut("t3");
      load_vecs("000000000010100000000000",
                "000000000001111001111000",
                "000000000001111111111110",
                "000000000000011110000000",
                "000000000000000000000000");
      run_vecs("t3 queued");

      reset_dut("t4");
      load_vecs("000000000011111000000000000000000000",
                "000000000001111001111001111001111000",
                "000000000001111111111111111111111110",
                "000000000000123332222221111110000000",
                "000000000000000100000000000000000000");
      run_vecs("t4 saturate");

      reset_dut("t6");
      load_vecs("00000000001010001000000000000000",
                "00000000000111100111100111100000",
                "00000000000111111111111111111000",
                "00000000000001111111111000000000",
                "00000000000000000000000000000000");
      run_vecs("t6 inc_dec");

      reset_dut("t7");
      load_vecs("000000000010000010000000",
                "000000000001111001111000",
                "000000000001111111111110",
                "000000000000000000000000",
                "000000000000000000000000");
      run_vecs("t7 gap_restart");

      // Asynchronous reset in the middle of a hold with two events queued.
      reset_dut("t5");
      for (int c = 0; c < 12; c++) begin
         #1 pulse = (c >= 9 && c <= 11);
         @(posedge clk);
      end
      #1 pulse = 1'b0;
      chk("t5 pre level",    int'(level),    1);
      chk("t5 pre pend_cnt", int'(pend_cnt), 2);
      #1 rst = 1'b0;
      #1;
      chk("t5 async level",    int'(level),    0);
      chk("t5 async busy",     int'(busy),     0);
      chk("t5 async pend_cnt", int'(pend_cnt), 0);
      #1 rst = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk($sformatf("t5 post c%0d level", c),    int'(level),    0);
         chk($sformatf("t5 post c%0d busy", c),     int'(busy),     0);
         chk($sformatf("t5 post c%0d pend_cnt", c), int'(pend_cnt), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
Converts single-cycle event pulses, such as the debounced button pulse or lock status strobes, into clean held levels of fixed duration. Each held level is followed by a mandatory low gap. It drives LED, buzzer and relay outputs in the digital lock, which need a visible or actuating on-time rather than an 8 ns strobe. Pulses that arrive while an output is in progress are queued in a saturating pending counter, so none are lost up to MAX_PEND.

Parameters:
HOLD_PER, 62_500_000, cycles the output level is held high per event (500 ms at 125 MHz); must be >= 1.
GAP_PER, 12_500_000, cycles the output is forced low after each hold, before the next queued event; must be >= 1.
MAX_PEND, 3, maximum number of queued events; must be >= 1.

Ports:
clk  input  1  system clock, 125 MHz.
rst  input  1  asynchronous, active-low reset.
pulse  input  1  event strobe, synchronous to clk; each high cycle counts as one event.
level  output  1  stretched output, registered.
busy  output  1  high in HOLD or GAP, registered.
pend_cnt  output  $clog2(MAX_PEND+1)  queued events not yet started.
overflow  output  1  one-cycle strobe when an event is dropped because the queue is full.

Behaviour:
- Reset (rst low, async): state = IDLE; level = 0, busy = 0, pend_cnt = 0, overflow = 0, counter = 0. Takes effect immediately, including mid-HOLD; level falls without waiting for a clock edge.
- One down-counter, width $clog2(max(HOLD_PER, GAP_PER)), shared by HOLD and GAP.
- FSM states: IDLE, HOLD, GAP.
- IDLE: on pulse = 1, go to HOLD and load counter = HOLD_PER-1. level and busy rise on the same edge, so latency is 1 cycle from the sampled pulse. pend_cnt is always 0 in IDLE.
- HOLD: level = 1. Decrement each cycle. At counter = 0, go to GAP and load GAP_PER-1. level is high for exactly HOLD_PER cycles.
- GAP: level = 0, busy = 1. Decrement each cycle. At counter = 0:
  - if pend_cnt > 0 or pulse = 1, go to HOLD and load HOLD_PER-1;
  - otherwise go to IDLE, and busy falls.
- Queue update, per cycle, when a new event is accepted:
  - inc = pulse and (state != IDLE or a start is already occurring from the queue).
  - dec = a start is taken from the queue (GAP exit with pend_cnt > 0).
  - inc and dec together: pend_cnt unchanged.
  - inc only, pend_cnt < MAX_PEND: pend_cnt + 1.
  - inc only, pend_cnt = MAX_PEND: pend_cnt unchanged, overflow = 1 for that cycle.
  - dec only: pend_cnt - 1.
- GAP exit with pend_cnt = 0 and pulse = 1: the pulse starts HOLD directly and is not queued.
- A pulse in the same cycle the IDLE to HOLD start occurs is the starting event, not an extra one.
- Pulses held high for multiple cycles count once per cycle; upstream guarantees single-cycle strobes.
- overflow is registered and never high for two consecutive cycles unless drops occur on consecutive cycles.
- Consecutive queued events yield a period of exactly HOLD_PER + GAP_PER cycles.

Decomposition:
- Package lock_pkg: state enum stretch_state_t {IDLE, HOLD, GAP}; constant CLK_HZ = 125_000_000; helper constants MS_CYCLES = CLK_HZ/1000 for deriving HOLD_PER and GAP_PER.
- The saturating up/down queue counter is a natural sub-module, sat_updn_cnt (parameter MAX, inputs inc and dec, outputs cnt and ovf). The FSM and timer stay in pulse_stretch.

Test Plan (HOLD_PER=4, GAP_PER=2, MAX_PEND=3, clk period 8 ns):
1. Hold rst low 2 cycles, pulse = 0 -> level, busy, pend_cnt and overflow all 0; release rst -> outputs remain 0.
2. Single pulse at cycle 10 -> level = 1 on cycles 11–14 (4 cycles), busy = 1 on cycles 11–16, IDLE from cycle 17, pend_cnt stays 0.
3. Pulses at cycles 10 and 12 -> pend_cnt = 1 from cycle 13; level high 11–14, low 15–16, high 17–20; pend_cnt returns to 0 at cycle 17; busy falls after cycle 22.
4. Pulses on 5 consecutive cycles, 10–14 -> pend_cnt goes 1, 2, 3 and then saturates at 3; overflow = 1 for exactly one cycle after the pulse at cycle 14; three further holds follow at a 6-cycle period.
5. rst driven low mid-HOLD at t = cycle 12 + 2 ns, with pend_cnt = 2 -> level, busy and pend_cnt go 0 immediately, not at the next edge; after release, no queued holds are issued.
6. pend_cnt = 1 and a pulse coincides with the final GAP cycle -> the next HOLD starts and pend_cnt stays 1 (simultaneous inc and dec); overflow stays 0.
